// File: rtl/cache_pkg.sv
// Shared cache-fill definitions: block geometry, memory timing, FSM state encoding.
// Used by the fill engine, the cache arrays and the I/D arbiter.
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY     = 4;
    localparam int TIMEOUT_CYCLES  = 64;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int WORD_BYTES  = 2;
    localparam int BLOCK_BYTES = WORDS_PER_BLOCK * WORD_BYTES;
    localparam int OFFSET_W    = $clog2(WORDS_PER_BLOCK);
    localparam int BYTE_OFF_W  = $clog2(BLOCK_BYTES);
    localparam int TAG_W       = ADDR_W - BYTE_OFF_W;
    localparam int WDOG_W      = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // Byte address of word idx inside the block whose upper address bits are tag.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0]    tag,
                                                     input logic [OFFSET_W-1:0] idx);
        return {tag, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Arbiter/memory-side signal bundle of the cache fill engine.
// master = fill engine view, slave = arbiter and main-memory view.
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_addr;
    logic [ADDR_W-1:0] fill_addr;
    logic              write_data_array;
    logic              write_tag_array;
    logic              fill_timeout;

    // memory_data is routed straight to the arrays by the arbiter, so the engine never sees it
    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        output fsm_busy,
        output mem_read_en,
        output memory_addr,
        output fill_addr,
        output write_data_array,
        output write_tag_array,
        output fill_timeout
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        output memory_data,
        input  fsm_busy,
        input  mem_read_en,
        input  memory_addr,
        input  fill_addr,
        input  write_data_array,
        input  write_tag_array,
        input  fill_timeout
    );

endinterface

// File: rtl/cache_fill_fsm_block_word_counter.sv
// Word-index counter for one block: counts 0..N-1, then raises a sticky terminal flag
// instead of wrapping, so it can never step into the next block.
module block_word_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {terminal, count} <= '0;
        end else if (clear) begin
            {terminal, count} <= '0;
        end else if (enable && !terminal) begin
            {terminal, count} <= {terminal, count} + (W+1)'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-service engine: fetches one whole block from pipelined main memory per arbitrated miss.
// Optional fill watchdog built only when CACHE_FILL_TIMEOUT_EN is defined.
//
// state   | meaning
// ST_IDLE | no fill in flight; samples miss_detected and latches the block base
// ST_FILL | issuing reads and writing returned words for the latched block
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    cache_fill_fsm_if.master bus
);

    localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(WORDS_PER_BLOCK - 1);

    fill_state_e         state_q;
    fill_state_e         state_d;
    logic [TAG_W-1:0]    base_q;
    logic [OFFSET_W-1:0] issue_cnt;
    logic [OFFSET_W-1:0] recv_cnt;
    logic                issue_done;
    logic                recv_done;
    logic                in_fill;
    logic                cnt_clear;
    logic                issue_en;
    logic                recv_en;
    logic                last_word;
    logic                timeout_hit;

    logic                busy_o;
    logic                read_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [ADDR_W-1:0]   fill_addr_o;
    logic                wr_data_o;
    logic                wr_tag_o;

    assign in_fill   = (state_q == ST_FILL);
    assign cnt_clear = !in_fill;
    assign issue_en  = in_fill && !issue_done;
    assign recv_en   = in_fill && bus.memory_data_valid && !recv_done;
    assign last_word = recv_en && (recv_cnt == LAST_IDX);

    block_word_counter #(.W(OFFSET_W)) u_issue_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (issue_en),
        .count    (issue_cnt),
        .terminal (issue_done)
    );

    block_word_counter #(.W(OFFSET_W)) u_recv_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (recv_en),
        .count    (recv_cnt),
        .terminal (recv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Base is captured only while idle, so a moving miss_address during a fill is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else if (!in_fill && bus.miss_detected) begin
            base_q <= bus.miss_address[ADDR_W-1:BYTE_OFF_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        read_o      = 1'b0;
        mem_addr_o  = word_addr(base_q, '0);
        fill_addr_o = word_addr(base_q, '0);
        wr_data_o   = 1'b0;
        wr_tag_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.miss_detected) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                busy_o      = 1'b1;
                read_o      = issue_en;
                mem_addr_o  = word_addr(base_q, issue_done ? LAST_IDX : issue_cnt);
                fill_addr_o = word_addr(base_q, recv_done ? LAST_IDX : recv_cnt);
                wr_data_o   = recv_en;
                wr_tag_o    = last_word;
                if (last_word || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.fsm_busy         = busy_o;
    assign bus.mem_read_en      = read_o;
    assign bus.memory_addr      = mem_addr_o;
    assign bus.fill_addr        = fill_addr_o;
    assign bus.write_data_array = wr_data_o;
    assign bus.write_tag_array  = wr_tag_o;

`ifdef CACHE_FILL_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              timeout_q;

    // Down-counter reloads on every returned word; expiry is the last silent FILL cycle.
    assign timeout_hit = in_fill && !bus.memory_data_valid && (wdog_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= WDOG_LOAD;
            timeout_q <= 1'b0;
        end else begin
            if (!in_fill || bus.memory_data_valid) begin
                wdog_q <= WDOG_LOAD;
            end else if (wdog_q != '0) begin
                wdog_q <= wdog_q - WDOG_W'(1);
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.fill_timeout = timeout_q;
`else
    assign timeout_hit      = 1'b0;
    assign bus.fill_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: random pipelined memory with stalls, checked
// cycle by cycle against a transaction-level model of one block fill.
module tb_cache_fill_fsm;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    cache_fill_fsm_if bus ();

    cache_fill_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model of the fill in progress: block base, reads issued, words received
    bit          m_fill;
    logic [15:0] m_base;
    int          m_iss;
    int          m_rcv;
    int          m_silent;
    bit          m_timeout;

    // pipelined memory: cycle at which each outstanding read may return, in issue order
    int          cyc = 0;
    int          ret_q[$];
    int          next_ok = 0;
    int          max_gap = 0;
    bit          mem_silent = 1'b0;

    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    int          n_writes;
    int          n_tags;
    int          busy_cycles;
    logic [15:0] tag_addr;
    bit          last_busy;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        n_writes    = 0;
        n_tags      = 0;
        busy_cycles = 0;
        tag_addr    = 16'h0;
    endtask

    task automatic chk_outputs_zero(input string t);
        chk({t, "_busy"},        16'(bus.fsm_busy), 16'd0);
        chk({t, "_mem_read_en"}, 16'(bus.mem_read_en), 16'd0);
        chk({t, "_memory_addr"}, bus.memory_addr, 16'd0);
        chk({t, "_fill_addr"},   bus.fill_addr, 16'd0);
        chk({t, "_write_data"},  16'(bus.write_data_array), 16'd0);
        chk({t, "_write_tag"},   16'(bus.write_tag_array), 16'd0);
        chk({t, "_timeout"},     16'(bus.fill_timeout), 16'd0);
    endtask

    task automatic model_reset();
        m_fill    = 1'b0;
        m_base    = 16'h0;
        m_iss     = 0;
        m_rcv     = 0;
        m_silent  = 0;
        m_timeout = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, check outputs 1 ns later, advance the model.
    task automatic step(input bit miss, input logic [15:0] maddr, input bit force_valid = 1'b0);
        bit          valid;
        bit          e_rd;
        bit          e_wr;
        bit          e_tag;
        logic [15:0] e_maddr;
        @(negedge clk);
        valid = force_valid;
        if (!force_valid && ret_q.size() > 0 && ret_q[0] <= cyc && cyc >= next_ok) begin
            valid = 1'b1;
            void'(ret_q.pop_front());
            next_ok = cyc + 1 + int'($urandom_range(32'(max_gap)));
        end
        bus.miss_detected     = miss;
        bus.miss_address      = maddr;
        bus.memory_data_valid = valid;
        bus.memory_data       = valid ? 16'($urandom) : 16'h0;
        #1;
        e_rd    = m_fill && (m_iss < WORDS_PER_BLOCK);
        e_maddr = m_fill ? m_base + 16'(2 * ((m_iss < WORDS_PER_BLOCK) ? m_iss : WORDS_PER_BLOCK - 1))
                         : m_base;
        e_wr    = m_fill && valid && (m_rcv < WORDS_PER_BLOCK);
        e_tag   = e_wr && (m_rcv == WORDS_PER_BLOCK - 1);
        chk("busy",             16'(bus.fsm_busy), 16'(m_fill));
        chk("mem_read_en",      16'(bus.mem_read_en), 16'(e_rd));
        chk("memory_addr",      bus.memory_addr, e_maddr);
        chk("write_data_array", 16'(bus.write_data_array), 16'(e_wr));
        chk("write_tag_array",  16'(bus.write_tag_array), 16'(e_tag));
        if (e_wr) begin
            chk("fill_addr", bus.fill_addr, m_base + 16'(2 * m_rcv));
        end else if (!m_fill) begin
            chk("fill_addr_idle", bus.fill_addr, m_base);
        end
        chk("fill_timeout", 16'(bus.fill_timeout), 16'(m_timeout));

        last_busy = bus.fsm_busy;
        if (bus.fsm_busy) busy_cycles++;
        if (bus.mem_read_en) begin
            rd_log.push_back(bus.memory_addr);
            if (!mem_silent) ret_q.push_back(cyc + MEM_LATENCY);
        end
        if (bus.write_data_array) begin
            wr_log.push_back(bus.fill_addr);
            n_writes++;
        end
        if (bus.write_tag_array) begin
            n_tags++;
            tag_addr = bus.fill_addr;
        end

        if (!m_fill) begin
            if (miss) begin
                m_fill   = 1'b1;
                m_base   = maddr & 16'hFFF0;
                m_iss    = 0;
                m_rcv    = 0;
                m_silent = 0;
            end
        end else begin
            if (e_rd) m_iss++;
            if (e_wr) m_rcv++;
            m_silent = valid ? 0 : m_silent + 1;
            if (e_tag) begin
                m_fill = 1'b0;
            end
`ifdef CACHE_FILL_TIMEOUT_EN
            else if (m_silent == TIMEOUT_CYCLES) begin
                m_fill    = 1'b0;
                m_timeout = 1'b1;
            end
`endif
        end
        cyc++;
    endtask

    task automatic run_fill(input bit miss, input logic [15:0] maddr);
        int n = 0;
        while (m_fill && n < 2000) begin
            step(miss, maddr);
            n++;
        end
        chk("fill_cycle_bound", 16'(n < 2000), 16'd1);
    endtask

    task automatic chk_block(input string t, input logic [15:0] base);
        chk({t, "_nreads"},  16'(rd_log.size()), 16'd8);
        chk({t, "_nwrites"}, 16'(n_writes), 16'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_log.size()) chk({t, "_rd_addr"}, rd_log[i], base + 16'(2 * i));
            if (i < wr_log.size()) chk({t, "_wr_addr"}, wr_log[i], base + 16'(2 * i));
        end
        chk({t, "_ntags"},    16'(n_tags), 16'd1);
        chk({t, "_tag_addr"}, tag_addr, base + 16'd14);
    endtask

    // Asynchronous reset applied mid-cycle, just after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          idle_cnt;
        int          n;
        logic [15:0] a;

        rst_n                 = 1'b0;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        model_reset();
        clear_logs();
        #1;
        chk_outputs_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset while the fourth word is due: fill aborted, late returns ignored
        max_gap = 0;
        clear_logs();
        step(1'b1, 16'h4A52);
        n = 0;
        while (n_writes < 3 && n < 100) begin
            step(1'b0, 16'h4A52);
            n++;
        end
        chk("t1_three_words", 16'(n_writes), 16'd3);
        do_reset();
        chk("t1_no_tag", 16'(n_tags), 16'd0);
        clear_logs();
        for (int i = 0; i < 10; i++) step(1'b0, 16'h4A52);
        chk("t1_late_returns_ignored", 16'(n_writes), 16'd0);
        ret_q.delete();

        // single miss, 4-cycle memory
        clear_logs();
        step(1'b1, 16'h1236);
        run_fill(1'b0, 16'h1236);
        chk_block("t2", 16'h1230);
        chk("t2_busy_cycles", 16'(busy_cycles), 16'(MEM_LATENCY + 8));

        // stalled memory, random block addresses
        max_gap = 3;
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom);
            clear_logs();
            step(1'b1, a);
            run_fill(1'b0, a);
            chk_block("t3", a & 16'hFFF0);
        end

        // miss held across fill end, top block of the address space
        max_gap = 0;
        clear_logs();
        step(1'b1, 16'h2002);
        run_fill(1'b1, 16'hFFF7);
        chk_block("t4a", 16'h2000);
        clear_logs();
        idle_cnt = 0;
        n = 0;
        do begin
            step(1'b1, 16'hFFF7);
            if (!last_busy) idle_cnt++;
            n++;
        end while (!last_busy && n < 10);
        chk("t4_busy_low_cycles", 16'(idle_cnt), 16'd1);
        run_fill(1'b0, 16'hFFF7);
        chk_block("t4b", 16'hFFF0);

        // spurious valid while idle, miss dropped mid-fill
        clear_logs();
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0804, 1'b1);
        chk("t5_idle_valid_writes", 16'(n_writes), 16'd0);
        step(1'b1, 16'h0804);
        step(1'b1, 16'h0804);
        step(1'b1, 16'h0804);
        run_fill(1'b0, 16'h0804);
        step(1'b0, 16'h0804, 1'b1);
        chk_block("t5", 16'h0800);

        // memory never answers
        mem_silent = 1'b1;
        clear_logs();
        step(1'b1, 16'h3000);
`ifdef CACHE_FILL_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYCLES + 8; i++) step(1'b0, 16'h3000);
        chk("t6_timeout_flag", 16'(bus.fill_timeout), 16'd1);
        chk("t6_back_idle", 16'(bus.fsm_busy), 16'd0);
        chk("t6_busy_cycles", 16'(busy_cycles), 16'(TIMEOUT_CYCLES));
        chk("t6_no_tag", 16'(n_tags), 16'd0);
`else
        for (int i = 0; i < 1000; i++) step(1'b0, 16'h3000);
        chk("t6_busy_cycles", 16'(busy_cycles), 16'd1000);
        chk("t6_no_timeout", 16'(bus.fill_timeout), 16'd0);
        chk("t6_no_writes", 16'(n_writes), 16'd0);
`endif
        do_reset();
        mem_silent = 1'b0;
        ret_q.delete();

        // normal fill after recovery
        max_gap = 2;
        clear_logs();
        step(1'b1, 16'h777C);
        run_fill(1'b0, 16'h777C);
        chk_block("t7", 16'h7770);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
